// File: rtl/vga_pkg.sv
// VGA timing defaults, colour bundle and drawer tile constants.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = 10;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Drawer tiles are BLOCK_WIDTH pixels square.
    localparam int BLOCK_WIDTH = 16;

    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'd0,
        TILE_WALL   = 2'd1,
        TILE_PLAYER = 2'd2,
        TILE_GOAL   = 2'd3
    } tile_t;

    function automatic rgb_t blank_rgb(
        input logic en,
        input rgb_t c
    );
        return en ? c : '0;
    endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Tick-enabled shift register that delays {active, hs, vs}
// so sync and blanking line up with the drawer's colour.
module vga_sync_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, tick};
            assign q = d;
        end else begin : g_shift
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++)
                        stage[i] <= '0;
                end else if (tick) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster generator: pixel divider, h/v counters,
// delay-matched blanked colour and sync outputs.
module vga_timing_controller #(
    parameter int H_ACTIVE   = vga_pkg::DEF_H_ACTIVE,
    parameter int H_FP       = vga_pkg::DEF_H_FP,
    parameter int H_SYNC     = vga_pkg::DEF_H_SYNC,
    parameter int H_BP       = vga_pkg::DEF_H_BP,
    parameter int V_ACTIVE   = vga_pkg::DEF_V_ACTIVE,
    parameter int V_FP       = vga_pkg::DEF_V_FP,
    parameter int V_SYNC     = vga_pkg::DEF_V_SYNC,
    parameter int V_BP       = vga_pkg::DEF_V_BP,
    parameter int CLK_DIV    = 2,
    parameter int PIPE_DELAY = 1,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    output int         col,
    output int         row,
    output logic       active,
    output logic       pixel_tick,
    output logic       frame_start,
    input  logic [3:0] pix_red,
    input  logic [3:0] pix_green,
    input  logic [3:0] pix_blue,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync,
    output logic       vsync
);

    import vga_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_ON =
        CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF =
        CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON =
        CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF =
        CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
            $error("CLK_DIV must be within 1..8");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_pipe
            $error("PIPE_DELAY must be within 0..4");
        end
        if (H_ACTIVE < 1 || H_FP < 0 || H_SYNC < 1 || H_BP < 0 ||
            V_ACTIVE < 1 || V_FP < 0 || V_SYNC < 1 || V_BP < 0 ||
            H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geo
            $error("VGA timing does not fit the 10-bit counters");
        end
    endgenerate

    logic [2:0]       div;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       dly;
    rgb_t             pix;
    rgb_t             rgb_q;

    assign pixel_tick = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div <= '0;
        else if (pixel_tick)
            div <= '0;
        else
            div <= div + 3'd1;
    end

    // frame_start rides the same tick that wraps both counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pixel_tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    if (v == V_LAST) begin
                        v           <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        v <= v + 1'b1;
                    end
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign active = (h < H_ACT) && (v < V_ACT);
    assign col    = active ? {22'd0, h} : 0;
    assign row    = active ? {22'd0, v} : 0;
    assign hs_raw = (h >= HS_ON) && (h < HS_OFF);
    assign vs_raw = (v >= VS_ON) && (v < VS_OFF);

    vga_sync_pipe #(
        .DEPTH (PIPE_DELAY),
        .W     (3)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .tick (pixel_tick),
        .d    ({active, hs_raw, vs_raw}),
        .q    (dly)
    );

    assign pix = {pix_red, pix_green, pix_blue};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            hsync <= SYNC_ACTIVE_LOW;
            vsync <= SYNC_ACTIVE_LOW;
        end else if (pixel_tick) begin
            rgb_q <= blank_rgb(dly[2], pix);
            hsync <= dly[1] ^ SYNC_ACTIVE_LOW;
            vsync <= dly[0] ^ SYNC_ACTIVE_LOW;
        end
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Four controllers (default and shrunken rasters) checked every clk
// against a position-arithmetic model of the raster.
module tb_vga_timing_controller;

    localparam int N = 4;
    localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div, pd;
        bit sal;
    } geo_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int         col_w [N];
    int         row_w [N];
    logic       act_w [N];
    logic       tick_w[N];
    logic       fs_w  [N];
    logic       hs_w  [N];
    logic       vs_w  [N];
    logic [3:0] pr [N];
    logic [3:0] pg [N];
    logic [3:0] pb [N];
    logic [3:0] r_w[N];
    logic [3:0] g_w[N];
    logic [3:0] b_w[N];

    geo_t       geo[N];
    logic [3:0] lut[1024];
    int         total = 0;
    int         bad = 0;

    vga_timing_controller u0 (
        .clk(clk), .rst(rst),
        .col(col_w[0]), .row(row_w[0]), .active(act_w[0]),
        .pixel_tick(tick_w[0]), .frame_start(fs_w[0]),
        .pix_red(pr[0]), .pix_green(pg[0]), .pix_blue(pb[0]),
        .vga_r(r_w[0]), .vga_g(g_w[0]), .vga_b(b_w[0]),
        .hsync(hs_w[0]), .vsync(vs_w[0])
    );

    vga_timing_controller #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(1), .PIPE_DELAY(0), .SYNC_ACTIVE_LOW(1'b1)
    ) u1 (
        .clk(clk), .rst(rst),
        .col(col_w[1]), .row(row_w[1]), .active(act_w[1]),
        .pixel_tick(tick_w[1]), .frame_start(fs_w[1]),
        .pix_red(pr[1]), .pix_green(pg[1]), .pix_blue(pb[1]),
        .vga_r(r_w[1]), .vga_g(g_w[1]), .vga_b(b_w[1]),
        .hsync(hs_w[1]), .vsync(vs_w[1])
    );

    vga_timing_controller #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(3), .PIPE_DELAY(4), .SYNC_ACTIVE_LOW(1'b0)
    ) u2 (
        .clk(clk), .rst(rst),
        .col(col_w[2]), .row(row_w[2]), .active(act_w[2]),
        .pixel_tick(tick_w[2]), .frame_start(fs_w[2]),
        .pix_red(pr[2]), .pix_green(pg[2]), .pix_blue(pb[2]),
        .vga_r(r_w[2]), .vga_g(g_w[2]), .vga_b(b_w[2]),
        .hsync(hs_w[2]), .vsync(vs_w[2])
    );

    vga_timing_controller #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(2), .PIPE_DELAY(1), .SYNC_ACTIVE_LOW(1'b1)
    ) u3 (
        .clk(clk), .rst(rst),
        .col(col_w[3]), .row(row_w[3]), .active(act_w[3]),
        .pixel_tick(tick_w[3]), .frame_start(fs_w[3]),
        .pix_red(pr[3]), .pix_green(pg[3]), .pix_blue(pb[3]),
        .vga_r(r_w[3]), .vga_g(g_w[3]), .vga_b(b_w[3]),
        .hsync(hs_w[3]), .vsync(vs_w[3])
    );

    function automatic int ht(input geo_t g);
        return g.ha + g.hf + g.hs + g.hb;
    endfunction

    function automatic int vt(input geo_t g);
        return g.va + g.vf + g.vs + g.vb;
    endfunction

    function automatic bit in_act(input geo_t g, input int p);
        int hh = p % ht(g);
        int vv = (p / ht(g)) % vt(g);
        return (hh < g.ha) && (vv < g.va);
    endfunction

    function automatic bit in_hs(input geo_t g, input int p);
        int hh = p % ht(g);
        return (hh >= g.ha + g.hf) && (hh < g.ha + g.hf + g.hs);
    endfunction

    function automatic bit in_vs(input geo_t g, input int p);
        int vv = (p / ht(g)) % vt(g);
        return (vv >= g.va + g.vf) && (vv < g.va + g.vf + g.vs);
    endfunction

    task automatic cmp(input int k, input string tag, input int e,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL u%0d %s edge=%0d got=%0d exp=%0d",
                   k, tag, e, got, exp);
        end
    endtask

    // The drawer answers with the colour of the position issued
    // pd ticks ago: green from a random table, blue echoes col.
    task automatic drive(input int k, input int e);
        geo_t g = geo[k];
        int p = e / g.div - g.pd;
        pr[k] = 4'hF;
        pg[k] = (p >= 0) ? lut[p % 1024] : 4'h0;
        pb[k] = (p >= 0 && in_act(g, p)) ? 4'(p % ht(g)) : 4'h0;
    endtask

    task automatic chk(input int k, input int e);
        geo_t g = geo[k];
        int n = e / g.div;
        int q = n - (g.pd + 1);
        bit ea = in_act(g, n);
        bit oa = (q >= 0) && in_act(g, q);
        int ecol = ea ? n % ht(g) : 0;
        int erow = ea ? (n / ht(g)) % vt(g) : 0;
        bit etick = (e % g.div) == g.div - 1;
        bit efs = (e > 0) && (e % g.div == 0) &&
                  (n % (ht(g) * vt(g)) == 0);
        logic [3:0] er = oa ? 4'hF : 4'h0;
        logic [3:0] eg = oa ? lut[q % 1024] : 4'h0;
        logic [3:0] eb = oa ? 4'(q % ht(g)) : 4'h0;
        bit ehs = ((q >= 0) && in_hs(g, q)) ^ g.sal;
        bit evs = ((q >= 0) && in_vs(g, q)) ^ g.sal;
        cmp(k, "col", e, col_w[k], ecol);
        cmp(k, "row", e, row_w[k], erow);
        cmp(k, "active", e, {31'd0, act_w[k]}, {31'd0, ea});
        cmp(k, "pixel_tick", e, {31'd0, tick_w[k]}, {31'd0, etick});
        cmp(k, "frame_start", e, {31'd0, fs_w[k]}, {31'd0, efs});
        cmp(k, "vga_r", e, {28'd0, r_w[k]}, {28'd0, er});
        cmp(k, "vga_g", e, {28'd0, g_w[k]}, {28'd0, eg});
        cmp(k, "vga_b", e, {28'd0, b_w[k]}, {28'd0, eb});
        cmp(k, "hsync", e, {31'd0, hs_w[k]}, {31'd0, ehs});
        cmp(k, "vsync", e, {31'd0, vs_w[k]}, {31'd0, evs});
    endtask

    initial begin
        int e;
        int hs_low;
        int act_cnt;
        int fs_first;
        int fs_last;

        geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1, 1'b1};
        geo[1] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                   1, 0, 1'b1};
        geo[2] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                   3, 4, 1'b0};
        geo[3] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
                   2, 1, 1'b1};
        for (int i = 0; i < 1024; i++)
            lut[i] = 4'($urandom);

        rst = 1'b1;
        for (int k = 0; k < N; k++) drive(k, 0);
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) chk(k, 0);
        end
        rst = 1'b0;

        e = 0;
        hs_low = 0;
        act_cnt = 0;
        fs_first = -1;
        fs_last = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            e++;
            for (int k = 0; k < N; k++) chk(k, e);
            if (hs_w[0] === 1'b0) hs_low++;
            if (e <= ht(geo[1]) * vt(geo[1]) && act_w[1] === 1'b1)
                act_cnt++;
            if (fs_w[2] === 1'b1) begin
                if (fs_first < 0) fs_first = e;
                fs_last = e;
            end
            for (int k = 0; k < N; k++) drive(k, e);
        end

        cmp(0, "hsync_low_clks", e, hs_low,
            geo[0].hs * geo[0].div);
        cmp(1, "active_per_frame", e, act_cnt,
            geo[1].ha * geo[1].va);
        cmp(2, "frame_period", e, fs_last - fs_first,
            ht(geo[2]) * vt(geo[2]) * geo[2].div);

        // Mid-frame reset: asynchronous, then held for 3 clk.
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) chk(k, 0);
        for (int k = 0; k < N; k++) drive(k, 0);
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) chk(k, 0);
        end
        rst = 1'b0;

        e = 0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            e++;
            for (int k = 0; k < N; k++) chk(k, e);
            for (int k = 0; k < N; k++) drive(k, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
